// File: rtl/river_gen.sv
// river_gen: per-frame pseudo-random river terrain generator.
// Each generated row updates centre, half-width and island width from a
// 16-bit LFSR. The row is presented on b1..b4 and strobed into the
// boundary memory with a one-cycle shift pulse.
module river_gen #(
  parameter int MIN_HALF  = 32,
  parameter int MAX_HALF  = 160,
  parameter int I_MAX     = 48,
  parameter int HOLD_ROWS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_start,
  input  logic [3:0]  rows_per_frame,
  input  logic [15:0] seed,
  input  logic        seed_load,
  output logic [9:0]  b1,
  output logic [9:0]  b2,
  output logic [9:0]  b3,
  output logic [9:0]  b4,
  output logic        shift,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int HW = $clog2(HOLD_ROWS + 1);

  localparam logic [15:0]        LFSR_INIT    = 16'hACE1;
  localparam logic [9:0]         C_INIT       = 10'd320;
  localparam logic [7:0]         W_INIT       = 8'd96;
  localparam logic [7:0]         GAP_SINGLE   = 8'd32;
  localparam logic [7:0]         GAP_AFTER    = 8'd128;
  localparam logic [7:0]         ISLAND_MIN_W = 8'd80;
  localparam logic [9:0]         B1_INIT      = C_INIT - {2'b00, W_INIT};
  localparam logic [9:0]         B2_INIT      = C_INIT + {2'b00, W_INIT};
  localparam logic signed [10:0] MIN_S        = 11'(MIN_HALF);
  localparam logic signed [10:0] MAX_S        = 11'(MAX_HALF);
  localparam logic [5:0]         I_MAX_V      = 6'(I_MAX);
  localparam logic [HW-1:0]      HOLD_V       = HW'(HOLD_ROWS);
  localparam logic [HW-1:0]      HOLD_ONE     = HW'(1);

  typedef enum logic [1:0] {
    CTL_IDLE,
    CTL_STEP,
    CTL_PUSH
  } ctl_e;

  typedef enum logic [1:0] {
    PH_SINGLE,
    PH_GROW,
    PH_HOLD,
    PH_SHRINK
  } phase_e;

  // Control state
  ctl_e        state_q, state_d;
  logic [3:0]  rem_q, rem_d;
  logic        zdone_q, zdone_d;
  logic        overrun_q, overrun_d;
  logic        step_en;
  logic        load_en;

  // Terrain state
  logic [9:0]    c_q;
  logic [7:0]    w_q;
  logic [5:0]    i_q;
  logic [7:0]    gap_q;
  logic [HW-1:0] hold_q;
  phase_e        phase_q;
  logic [15:0]   lfsr_q;
  logic [9:0]    b1_q, b2_q, b3_q, b4_q;

  // Next-row terrain values
  logic [9:0]    nxt_c;
  logic [7:0]    nxt_w;
  logic [5:0]    nxt_i;
  logic [7:0]    nxt_gap;
  logic [HW-1:0] nxt_hold;
  phase_e        nxt_phase;
  logic [15:0]   nxt_lfsr;
  logic [9:0]    nxt_b1, nxt_b2, nxt_b3, nxt_b4;
  logic [15:0]   seed_val;

  // 11-bit signed working values for the clamped random walk
  logic signed [10:0] c_s, w_s, i_s;
  logic signed [10:0] w_step, c_step;
  logic signed [10:0] w_try, w_new;
  logic signed [10:0] c_try, c_lo, c_hi;
  logic               dec_blocked;

  assign seed_val = (seed == 16'd0) ? LFSR_INIT : seed;

  // Control registers: FSM state, rows remaining, zero-row done and overrun flag.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CTL_IDLE;
      rem_q     <= 4'd0;
      zdone_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      zdone_q   <= zdone_d;
      overrun_q <= overrun_d;
    end
  end

  // Control next-state and strobes: accept frames, alternate STEP/PUSH, count rows.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    zdone_d   = 1'b0;
    overrun_d = overrun_q;
    step_en   = 1'b0;
    load_en   = 1'b0;
    shift     = 1'b0;
    done      = zdone_q;

    unique case (state_q)
      CTL_IDLE: begin
        // A seed load takes priority and swallows a coincident frame_start.
        if (seed_load) begin
          load_en   = 1'b1;
          overrun_d = 1'b0;
        end else if (frame_start && enable) begin
          rem_d = rows_per_frame;
          if (rows_per_frame == 4'd0) begin
            zdone_d = 1'b1;
          end else begin
            state_d = CTL_STEP;
          end
        end
      end
      CTL_STEP: begin
        step_en = 1'b1;
        state_d = CTL_PUSH;
      end
      CTL_PUSH: begin
        shift = 1'b1;
        rem_d = rem_q - 4'd1;
        if (rem_q == 4'd1) begin
          done    = 1'b1;
          state_d = CTL_IDLE;
        end else begin
          state_d = CTL_STEP;
        end
      end
      default: state_d = CTL_IDLE;
    endcase

    // A frame request while rows are still being produced is dropped but remembered.
    if (frame_start && enable && (state_q != CTL_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  // Next-row terrain: width walk, centre walk, island phase, LFSR advance, output encoding.
  always_comb begin
    c_s = {1'b0, c_q};
    w_s = {3'b000, w_q};
    i_s = {5'b00000, i_q};

    // Width step from lfsr[3:2]; narrowing is refused if it would squeeze the island.
    dec_blocked = (w_s - 11'sd1) < (i_s + 11'sd32);
    unique case (lfsr_q[3:2])
      2'b00:   w_step = dec_blocked ? 11'sd0 : -11'sd1;
      2'b11:   w_step = 11'sd1;
      default: w_step = 11'sd0;
    endcase
    w_try = w_s + w_step;
    if (w_try < MIN_S) begin
      w_new = MIN_S;
    end else if (w_try > MAX_S) begin
      w_new = MAX_S;
    end else begin
      w_new = w_try;
    end
    nxt_w = w_new[7:0];

    // Centre step from lfsr[1:0], clamped against the new width to stay on screen.
    unique case (lfsr_q[1:0])
      2'b00:   c_step = -11'sd2;
      2'b11:   c_step = 11'sd2;
      default: c_step = 11'sd0;
    endcase
    c_try = c_s + c_step;
    c_lo  = 11'sd16 + w_new;
    c_hi  = 11'sd623 - w_new;
    if (c_try < c_lo) begin
      nxt_c = c_lo[9:0];
    end else if (c_try > c_hi) begin
      nxt_c = c_hi[9:0];
    end else begin
      nxt_c = c_try[9:0];
    end

    // Island phase machine.
    nxt_phase = phase_q;
    nxt_i     = i_q;
    nxt_gap   = gap_q;
    nxt_hold  = hold_q;
    unique case (phase_q)
      PH_SINGLE: begin
        nxt_gap = gap_q - 8'd1;
        if (gap_q == 8'd1) begin
          nxt_gap = GAP_SINGLE;
          if ((lfsr_q[7:5] == 3'b000) && (nxt_w >= ISLAND_MIN_W)) begin
            nxt_phase = PH_GROW;
          end
        end
      end
      PH_GROW: begin
        nxt_i = i_q + 6'd1;
        if ((i_q + 6'd1) == I_MAX_V) begin
          nxt_phase = PH_HOLD;
          nxt_hold  = HOLD_V;
        end
      end
      PH_HOLD: begin
        nxt_hold = hold_q - HOLD_ONE;
        if (hold_q == HOLD_ONE) begin
          nxt_phase = PH_SHRINK;
        end
      end
      PH_SHRINK: begin
        nxt_i = i_q - 6'd1;
        if (i_q == 6'd1) begin
          nxt_phase = PH_SINGLE;
          nxt_gap   = GAP_AFTER;
        end
      end
      default: nxt_phase = PH_SINGLE;
    endcase

    // Fibonacci LFSR, taps 16,14,13,11, feedback into bit 0.
    nxt_lfsr = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Boundary encoding: b3 == 0 marks a single channel.
    nxt_b1 = nxt_c - {2'b00, nxt_w};
    if (nxt_i == 6'd0) begin
      nxt_b2 = nxt_c + {2'b00, nxt_w};
      nxt_b3 = 10'd0;
      nxt_b4 = 10'd0;
    end else begin
      nxt_b2 = nxt_c - {4'b0000, nxt_i};
      nxt_b3 = nxt_c + {4'b0000, nxt_i};
      nxt_b4 = nxt_c + {2'b00, nxt_w};
    end
  end

  // Terrain registers: restart on reset or seed load, advance one row per STEP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q     <= C_INIT;
      w_q     <= W_INIT;
      i_q     <= 6'd0;
      gap_q   <= GAP_SINGLE;
      hold_q  <= '0;
      phase_q <= PH_SINGLE;
      lfsr_q  <= LFSR_INIT;
      b1_q    <= B1_INIT;
      b2_q    <= B2_INIT;
      b3_q    <= 10'd0;
      b4_q    <= 10'd0;
    end else if (load_en) begin
      c_q     <= C_INIT;
      w_q     <= W_INIT;
      i_q     <= 6'd0;
      gap_q   <= GAP_SINGLE;
      hold_q  <= '0;
      phase_q <= PH_SINGLE;
      lfsr_q  <= seed_val;
      b1_q    <= B1_INIT;
      b2_q    <= B2_INIT;
      b3_q    <= 10'd0;
      b4_q    <= 10'd0;
    end else if (step_en) begin
      c_q     <= nxt_c;
      w_q     <= nxt_w;
      i_q     <= nxt_i;
      gap_q   <= nxt_gap;
      hold_q  <= nxt_hold;
      phase_q <= nxt_phase;
      lfsr_q  <= nxt_lfsr;
      b1_q    <= nxt_b1;
      b2_q    <= nxt_b2;
      b3_q    <= nxt_b3;
      b4_q    <= nxt_b4;
    end
  end

  assign b1      = b1_q;
  assign b2      = b2_q;
  assign b3      = b3_q;
  assign b4      = b4_q;
  assign busy    = (state_q != CTL_IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_river_gen.sv
// tb_river_gen: scoreboard bench for river_gen with a behavioural terrain model.
module tb_river_gen;

  localparam int MIN_HALF  = 32;
  localparam int MAX_HALF  = 160;
  localparam int I_MAX     = 48;
  localparam int HOLD_ROWS = 64;
  localparam int LONG_ROWS = 20000;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        frame_start;
  logic [3:0]  rows_per_frame;
  logic [15:0] seed;
  logic        seed_load;
  logic [9:0]  b1, b2, b3, b4;
  logic        shift, busy, done, overrun;

  river_gen #(
    .MIN_HALF (MIN_HALF),
    .MAX_HALF (MAX_HALF),
    .I_MAX    (I_MAX),
    .HOLD_ROWS(HOLD_ROWS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .frame_start   (frame_start),
    .rows_per_frame(rows_per_frame),
    .seed          (seed),
    .seed_load     (seed_load),
    .b1            (b1),
    .b2            (b2),
    .b3            (b3),
    .b4            (b4),
    .shift         (shift),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {SINGLE, GROW, HOLD, SHRINK} phase_t;
  typedef struct {
    int b1;
    int b2;
    int b3;
    int b4;
    bit last;
  } row_t;

  row_t        exp_q[$];
  int          m_c, m_w, m_i, m_gap, m_hold;
  phase_t      m_phase;
  int unsigned m_lfsr;
  int          rows_total = 0;

  function automatic int clamp(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_seed(int unsigned s);
    m_c     = 320;
    m_w     = 96;
    m_i     = 0;
    m_gap   = 32;
    m_hold  = 0;
    m_phase = SINGLE;
    m_lfsr  = (s == 0) ? 32'hACE1 : s;
  endfunction

  function automatic row_t model_row();
    row_t r;
    int dw, dc, fb, cbits, wbits;
    cbits = int'(m_lfsr & 3);
    wbits = int'((m_lfsr >> 2) & 3);
    dc = (cbits == 0) ? -2 : (cbits == 3) ? 2 : 0;
    dw = (wbits == 0) ? -1 : (wbits == 3) ? 1 : 0;
    if (dw < 0 && (m_w - 1) < (m_i + 32)) dw = 0;
    m_w = clamp(m_w + dw, MIN_HALF, MAX_HALF);
    m_c = clamp(m_c + dc, 16 + m_w, 623 - m_w);
    case (m_phase)
      SINGLE: begin
        m_gap--;
        if (m_gap == 0) begin
          m_gap = 32;
          if (((m_lfsr >> 5) & 7) == 0 && m_w >= 80) m_phase = GROW;
        end
      end
      GROW: begin
        m_i++;
        if (m_i == I_MAX) begin
          m_phase = HOLD;
          m_hold  = HOLD_ROWS;
        end
      end
      HOLD: begin
        m_hold--;
        if (m_hold == 0) m_phase = SHRINK;
      end
      SHRINK: begin
        m_i--;
        if (m_i == 0) begin
          m_phase = SINGLE;
          m_gap   = 128;
        end
      end
    endcase
    fb = int'(((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1);
    m_lfsr = ((m_lfsr << 1) | fb) & 32'hFFFF;
    r.b1 = m_c - m_w;
    if (m_i == 0) begin
      r.b2 = m_c + m_w;
      r.b3 = 0;
      r.b4 = 0;
    end else begin
      r.b2 = m_c - m_i;
      r.b3 = m_c + m_i;
      r.b4 = m_c + m_w;
    end
    r.last = 1'b0;
    rows_total++;
    return r;
  endfunction

  // ---------------- expected timing window of the current frame ----------------
  int cyc      = 0;
  int fr_k     = 0;
  int fr_n     = 0;
  bit fr_valid = 1'b0;

  // island tracking across observed rows
  bit prev_ok     = 1'b0;
  int prev_i      = 0;
  bit seen_max    = 1'b0;
  int cycles_seen = 0;

  // monitor scratch
  row_t mr;
  bit   exp_busy, exp_shift, exp_done;
  int   ob1, ob2, ob3, ob4, right, wd, obs_i;

  // Monitor: timing of busy/shift/done every cycle, row contents on every shift.
  always @(posedge clk) begin
    cyc++;
    #2;
    exp_busy  = fr_valid && fr_n > 0 && cyc >= fr_k + 1 && cyc <= fr_k + 2 * fr_n;
    exp_shift = fr_valid && fr_n > 0 && cyc >= fr_k + 2 && cyc <= fr_k + 2 * fr_n
                && ((cyc - fr_k) % 2 == 0);
    exp_done  = fr_valid && cyc == fr_k + ((fr_n == 0) ? 1 : 2 * fr_n);
    check("busy", {31'd0, busy}, {31'd0, exp_busy});
    check("shift_timing", {31'd0, shift}, {31'd0, exp_shift});
    check("done_timing", {31'd0, done}, {31'd0, exp_done});
    if (shift === 1'b1) begin
      check("row_available", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        mr  = exp_q.pop_front();
        ob1 = int'(b1);
        ob2 = int'(b2);
        ob3 = int'(b3);
        ob4 = int'(b4);
        check("row_b1", ob1, mr.b1);
        check("row_b2", ob2, mr.b2);
        check("row_b3", ob3, mr.b3);
        check("row_b4", ob4, mr.b4);
        check("done_on_last_row", {31'd0, done}, {31'd0, mr.last});
        right = (ob3 == 0) ? ob2 : ob4;
        wd    = right - ob1;
        check("left_bank_min", (ob1 >= 16) ? 1 : 0, 1);
        check("right_bank_max", (right <= 623) ? 1 : 0, 1);
        check("width_range", (wd >= 2 * MIN_HALF && wd <= 2 * MAX_HALF) ? 1 : 0, 1);
        if (ob3 != 0) begin
          check("split_order", (ob1 < ob2 && ob2 < ob3 && ob3 < ob4) ? 1 : 0, 1);
          check("island_max", (ob3 - ob2 <= 2 * I_MAX) ? 1 : 0, 1);
          obs_i = (ob3 - ob2) / 2;
        end else begin
          obs_i = 0;
        end
        if (prev_ok) begin
          check("island_step", ((obs_i - prev_i) <= 1 && (prev_i - obs_i) <= 1) ? 1 : 0, 1);
        end
        if (obs_i == I_MAX) seen_max = 1'b1;
        if (obs_i == 0 && seen_max) begin
          cycles_seen++;
          seen_max = 1'b0;
        end
        prev_i  = obs_i;
        prev_ok = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input int n, input bit en);
    row_t r;
    @(negedge clk);
    enable         = en;
    rows_per_frame = 4'(n);
    frame_start    = 1'b1;
    if (en) begin
      fr_k     = cyc;
      fr_n     = n;
      fr_valid = 1'b1;
      for (int j = 1; j <= n; j++) begin
        r      = model_row();
        r.last = (j == n);
        exp_q.push_back(r);
      end
    end
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit en);
    start_frame(n, en);
    if (en) repeat (2 * n + 1) @(negedge clk);
  endtask

  task automatic do_seed(input logic [15:0] s, input bit with_frame);
    @(negedge clk);
    seed           = s;
    seed_load      = 1'b1;
    enable         = 1'b1;
    rows_per_frame = 4'd3;
    frame_start    = with_frame;
    model_seed(32'(s));
    prev_ok  = 1'b0;
    seen_max = 1'b0;
    @(negedge clk);
    seed_load   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_b1"}, {22'd0, b1}, 32'd224);
    check({tag, "_b2"}, {22'd0, b2}, 32'd416);
    check({tag, "_b3"}, {22'd0, b3}, 32'd0);
    check({tag, "_b4"}, {22'd0, b4}, 32'd0);
    check({tag, "_shift"}, {31'd0, shift}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  // Watchdog: the run must finish on its own.
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset          = 1'b1;
    enable         = 1'b0;
    frame_start    = 1'b0;
    rows_per_frame = 4'd0;
    seed           = 16'd0;
    seed_load      = 1'b0;
    model_seed(32'hACE1);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Three-row frame from the power-on seed.
    run_frame(3, 1'b1);
    repeat (2) @(negedge clk);

    // Zero-row frame: done only, never busy.
    run_frame(0, 1'b1);
    repeat (3) @(negedge clk);

    // Frame request while disabled is ignored.
    start_frame(3, 1'b0);
    repeat (4) @(negedge clk);

    // Overrun: second frame_start during the first PUSH of a 4-row frame.
    start_frame(4, 1'b1);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (7) @(negedge clk);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    do_seed(16'h1234, 1'b0);
    check("overrun_cleared", {31'd0, overrun}, 32'd0);
    run_frame(4, 1'b1);

    // Seed 0 behaves as the power-on seed.
    do_seed(16'h0000, 1'b0);
    run_frame(3, 1'b1);

    // The same seed twice reproduces the same rows.
    do_seed(16'hBEEF, 1'b0);
    run_frame(5, 1'b1);
    do_seed(16'hBEEF, 1'b0);
    run_frame(5, 1'b1);

    // seed_load with frame_start: the frame is dropped, terrain restarts.
    do_seed(16'h5A5A, 1'b1);
    repeat (4) @(negedge clk);
    run_frame(2, 1'b1);

    // Asynchronous reset in the middle of a frame with overrun set.
    start_frame(6, 1'b1);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(posedge clk);
    #3;
    reset    = 1'b1;
    fr_valid = 1'b0;
    exp_q.delete();
    prev_ok  = 1'b0;
    seen_max = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_seed(32'hACE1);
    repeat (6) @(negedge clk);

    // Long randomized run at 15 rows per frame with random enable.
    do_seed(16'($urandom), 1'b0);
    rows_total = 0;
    while (rows_total < LONG_ROWS) begin
      run_frame(15, ($urandom_range(0, 3) != 0));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("island_cycle_seen", (cycles_seen > 0) ? 32'd1 : 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
